// File: rtl/can_destuff_ctrl.sv
// CAN receive-path bit destuffer: idle/SOF detection, stuff-bit removal, stuff-error flagging.
// Optional stuff-error counter on err_cnt is built when CAN_STUFF_ERR_CNT_EN is defined.
module can_destuff_ctrl #(
    parameter int unsigned STUFF_LEN = 5,
    parameter int unsigned IDLE_LEN  = 11
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       RX,
    input  logic       SP,
    input  logic       stuff_en,
    input  logic       frame_end,
    output logic       bit_out,
    output logic       bit_valid,
    output logic       stuff_bit,
    output logic       stuff_err,
    output logic       sof,
    output logic       bus_idle,
    output logic [7:0] err_cnt
);

    localparam int unsigned RUN_W = $clog2(STUFF_LEN + 1);
    localparam int unsigned REC_W = $clog2(IDLE_LEN + 1);

    typedef enum logic [1:0] {
        IDLE_WAIT = 2'd0,
        BUS_IDLE  = 2'd1,
        RECEIVE   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [REC_W-1:0] rec_q, rec_d;
    logic             prev_q, prev_d;
    logic             bit_out_d, bit_valid_d, stuff_bit_d, stuff_err_d, sof_d, bus_idle_d;

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE_WAIT;
            run_q     <= '0;
            rec_q     <= '0;
            prev_q    <= 1'b1;
            bit_out   <= 1'b0;
            bit_valid <= 1'b0;
            stuff_bit <= 1'b0;
            stuff_err <= 1'b0;
            sof       <= 1'b0;
            bus_idle  <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_q     <= run_d;
            rec_q     <= rec_d;
            prev_q    <= prev_d;
            bit_out   <= bit_out_d;
            bit_valid <= bit_valid_d;
            stuff_bit <= stuff_bit_d;
            stuff_err <= stuff_err_d;
            sof       <= sof_d;
            bus_idle  <= bus_idle_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        run_d       = run_q;
        rec_d       = rec_q;
        prev_d      = prev_q;
        bit_out_d   = bit_out;
        bit_valid_d = 1'b0;
        stuff_bit_d = 1'b0;
        stuff_err_d = 1'b0;
        sof_d       = 1'b0;

        case (state_q)
            IDLE_WAIT: begin
                if (SP) begin
                    if (!RX) begin
                        rec_d = '0;
                    end else if (rec_q >= REC_W'(IDLE_LEN - 1)) begin
                        rec_d   = '0;
                        state_d = BUS_IDLE;
                    end else begin
                        rec_d = rec_q + REC_W'(1);
                    end
                end
            end
            BUS_IDLE: begin
                if (SP && !RX) begin
                    sof_d       = 1'b1;
                    bit_valid_d = 1'b1;
                    bit_out_d   = 1'b0;
                    prev_d      = 1'b0;
                    run_d       = RUN_W'(1);
                    state_d     = RECEIVE;
                end
            end
            RECEIVE: begin
                // frame_end beats a coincident SP: the bit is dropped
                if (frame_end) begin
                    run_d   = '0;
                    rec_d   = '0;
                    state_d = IDLE_WAIT;
                end else if (SP) begin
                    if (!stuff_en) begin
                        bit_valid_d = 1'b1;
                        bit_out_d   = RX;
                        run_d       = '0;
                        prev_d      = RX;
                    end else if (run_q == RUN_W'(STUFF_LEN)) begin
                        if (RX != prev_q) begin
                            stuff_bit_d = 1'b1;
                            run_d       = RUN_W'(1);
                            prev_d      = RX;
                        end else begin
                            stuff_err_d = 1'b1;
                            run_d       = '0;
                            rec_d       = '0;
                            state_d     = IDLE_WAIT;
                        end
                    end else begin
                        // run_q < STUFF_LEN here, so the increment cannot overflow
                        bit_valid_d = 1'b1;
                        bit_out_d   = RX;
                        run_d       = (RX == prev_q) ? run_q + RUN_W'(1) : RUN_W'(1);
                        prev_d      = RX;
                    end
                end
            end
            default: state_d = IDLE_WAIT;
        endcase

        bus_idle_d = (state_d == BUS_IDLE);
    end

`ifdef CAN_STUFF_ERR_CNT_EN
    logic [7:0] err_cnt_q;

    // Saturating stuff-error counter, cleared only by reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            err_cnt_q <= 8'd0;
        end else if (stuff_err_d && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_can_destuff_ctrl.sv
// Directed testbench for can_destuff_ctrl; each task drives one scenario and checks inline.
module tb_can_destuff_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       RX;
    logic       SP;
    logic       stuff_en;
    logic       frame_end;
    logic       bit_out;
    logic       bit_valid;
    logic       stuff_bit;
    logic       stuff_err;
    logic       sof;
    logic       bus_idle;
    logic [7:0] err_cnt;

    int checks = 0;
    int errors = 0;

    can_destuff_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .RX        (RX),
        .SP        (SP),
        .stuff_en  (stuff_en),
        .frame_end (frame_end),
        .bit_out   (bit_out),
        .bit_valid (bit_valid),
        .stuff_bit (stuff_bit),
        .stuff_err (stuff_err),
        .sof       (sof),
        .bus_idle  (bus_idle),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    // One SP cycle; on return the registered response to that bit is visible
    task automatic drive_bit(input logic rx, input logic se, input logic fe);
        RX = rx; SP = 1'b1; stuff_en = se; frame_end = fe;
        @(posedge clk); #1;
        SP = 1'b0; frame_end = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b0; SP = 1'b0; frame_end = 1'b0;
        idle_cycle();
        reset = 1'b1;
    endtask

    // Reset then 11 recessive bits: DUT ends in BUS_IDLE
    task automatic go_idle();
        pulse_reset();
        for (int i = 0; i < 11; i++) drive_bit(1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b0; RX = 1'b1; SP = 1'b0; stuff_en = 1'b0; frame_end = 1'b0;
        repeat (2) idle_cycle();
        checks++;
        if ({bit_out, bit_valid, stuff_bit, stuff_err, sof, bus_idle, err_cnt} !== 14'd0) begin
            errors++;
            $display("FAIL reset_outputs got %b exp 0", {bit_out, bit_valid, stuff_bit, stuff_err, sof, bus_idle, err_cnt});
        end
        reset = 1'b1;
    endtask

    task automatic test_idle_detect();
        int early;
        pulse_reset();
        early = 0;
        for (int i = 0; i < 10; i++) begin
            drive_bit(1'b1, 1'b0, 1'b0);
            early += int'(bus_idle);
        end
        checks++;
        if (early !== 0) begin errors++; $display("FAIL idle_early got %0d exp 0", early); end
        drive_bit(1'b1, 1'b0, 1'b0);
        checks++;
        if (bus_idle !== 1'b1) begin errors++; $display("FAIL idle_after_11 got %b exp 1", bus_idle); end
        idle_cycle();
        checks++;
        if (bus_idle !== 1'b1) begin errors++; $display("FAIL idle_level_hold got %b exp 1", bus_idle); end
        // a dominant bit in the middle restarts the recessive count
        pulse_reset();
        for (int i = 0; i < 10; i++) drive_bit(1'b1, 1'b0, 1'b0);
        drive_bit(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) drive_bit(1'b1, 1'b0, 1'b0);
        checks++;
        if (bus_idle !== 1'b0) begin errors++; $display("FAIL idle_broken got %b exp 0", bus_idle); end
    endtask

    task automatic test_stuff_removal();
        int nsof, nval, nzero, nstuff;
        go_idle();
        drive_bit(1'b0, 1'b1, 1'b0);
        checks++;
        if ({sof, bit_valid, bit_out, bus_idle} !== 4'b1100) begin
            errors++; $display("FAIL sof_bit got %b exp 1100", {sof, bit_valid, bit_out, bus_idle});
        end
        nsof = int'(sof); nval = int'(bit_valid); nzero = int'(bit_valid & ~bit_out); nstuff = 0;
        idle_cycle();
        checks++;
        if ({sof, bit_valid} !== 2'b00) begin errors++; $display("FAIL pulse_width got %b exp 00", {sof, bit_valid}); end
        for (int i = 0; i < 4; i++) begin
            drive_bit(1'b0, 1'b1, 1'b0);
            nsof += int'(sof); nval += int'(bit_valid);
            nzero += int'(bit_valid & ~bit_out); nstuff += int'(stuff_bit);
        end
        checks++;
        if (nsof !== 1 || nval !== 5 || nzero !== 5 || nstuff !== 0) begin
            errors++; $display("FAIL removal_counts got sof=%0d val=%0d zero=%0d stuff=%0d exp 1 5 5 0", nsof, nval, nzero, nstuff);
        end
        drive_bit(1'b1, 1'b1, 1'b0);
        checks++;
        if ({stuff_bit, bit_valid, stuff_err} !== 3'b100) begin
            errors++; $display("FAIL removal_stuff got %b exp 100", {stuff_bit, bit_valid, stuff_err});
        end
    endtask

    task automatic test_stuff_error();
        int nval;
        go_idle();
        nval = 0;
        for (int i = 0; i < 5; i++) begin
            drive_bit(1'b0, 1'b1, 1'b0);
            nval += int'(bit_valid);
        end
        checks++;
        if (nval !== 5) begin errors++; $display("FAIL err_valid_count got %0d exp 5", nval); end
        drive_bit(1'b0, 1'b1, 1'b0);
        checks++;
        if ({stuff_err, bit_valid, stuff_bit} !== 3'b100) begin
            errors++; $display("FAIL err_pulse got %b exp 100", {stuff_err, bit_valid, stuff_bit});
        end
        checks++;
`ifdef CAN_STUFF_ERR_CNT_EN
        if (err_cnt !== 8'd1) begin errors++; $display("FAIL err_cnt_one got %0d exp 1", err_cnt); end
`else
        if (err_cnt !== 8'd0) begin errors++; $display("FAIL err_cnt_off got %0d exp 0", err_cnt); end
`endif
        // back in IDLE_WAIT: a dominant bit is not SOF, and 11 recessive bits are needed again
        drive_bit(1'b0, 1'b1, 1'b0);
        checks++;
        if ({sof, bit_valid, stuff_err} !== 3'b000) begin
            errors++; $display("FAIL err_state_idlewait got %b exp 000", {sof, bit_valid, stuff_err});
        end
        for (int i = 0; i < 10; i++) drive_bit(1'b1, 1'b0, 1'b0);
        checks++;
        if (bus_idle !== 1'b0) begin errors++; $display("FAIL err_reidle_early got %b exp 0", bus_idle); end
        drive_bit(1'b1, 1'b0, 1'b0);
        checks++;
        if (bus_idle !== 1'b1) begin errors++; $display("FAIL err_reidle got %b exp 1", bus_idle); end
    endtask

    task automatic test_stuff_next_run();
        int nval, nones, nstuff;
        logic [10:0] pattern = 11'b00000_1_1111_0;
        go_idle();
        nval = 0; nones = 0; nstuff = 0;
        for (int i = 10; i >= 0; i--) begin
            drive_bit(pattern[i], 1'b1, 1'b0);
            nval += int'(bit_valid); nones += int'(bit_valid & bit_out);
            nstuff += int'(stuff_bit);
            if (i == 5) begin
                checks++;
                if (stuff_bit !== 1'b1) begin errors++; $display("FAIL next_run_first_stuff got %b exp 1", stuff_bit); end
            end
        end
        checks++;
        if ({stuff_bit, bit_valid} !== 2'b10) begin
            errors++; $display("FAIL next_run_last_stuff got %b exp 10", {stuff_bit, bit_valid});
        end
        checks++;
        if (nval !== 9 || nones !== 4 || nstuff !== 2) begin
            errors++; $display("FAIL next_run_counts got val=%0d ones=%0d stuff=%0d exp 9 4 2", nval, nones, nstuff);
        end
    endtask

    task automatic test_unstuffed();
        int nval, nstuff, nerr;
        go_idle();
        drive_bit(1'b0, 1'b1, 1'b0);
        nval = 0; nstuff = 0; nerr = 0;
        for (int i = 0; i < 7; i++) begin
            drive_bit(1'b0, 1'b0, 1'b0);
            nval += int'(bit_valid & ~bit_out); nstuff += int'(stuff_bit); nerr += int'(stuff_err);
        end
        checks++;
        if (nval !== 7 || nstuff !== 0 || nerr !== 0) begin
            errors++; $display("FAIL unstuffed got val=%0d stuff=%0d err=%0d exp 7 0 0", nval, nstuff, nerr);
        end
        // stuff_en rising starts a fresh run: five equal bits are legal payload
        nval = 0; nerr = 0;
        for (int i = 0; i < 5; i++) begin
            drive_bit(1'b0, 1'b1, 1'b0);
            nval += int'(bit_valid); nerr += int'(stuff_err) + int'(stuff_bit);
        end
        checks++;
        if (nval !== 5 || nerr !== 0) begin
            errors++; $display("FAIL restuff_new_run got val=%0d errstuff=%0d exp 5 0", nval, nerr);
        end
    endtask

    task automatic test_priority();
        go_idle();
        drive_bit(1'b0, 1'b1, 1'b0);
        drive_bit(1'b1, 1'b1, 1'b0);
        drive_bit(1'b0, 1'b1, 1'b1);
        checks++;
        if ({bit_valid, stuff_bit, stuff_err, sof} !== 4'b0000) begin
            errors++; $display("FAIL frame_end_drop got %b exp 0000", {bit_valid, stuff_bit, stuff_err, sof});
        end
        drive_bit(1'b0, 1'b1, 1'b0);
        checks++;
        if ({bit_valid, sof, bus_idle} !== 3'b000) begin
            errors++; $display("FAIL frame_end_idlewait got %b exp 000", {bit_valid, sof, bus_idle});
        end
    endtask

    task automatic test_reset_mid();
        go_idle();
        drive_bit(1'b0, 1'b1, 1'b0);
        reset = 1'b0;
        drive_bit(1'b1, 1'b1, 1'b0);
        checks++;
        if ({bit_out, bit_valid, stuff_bit, stuff_err, sof, bus_idle, err_cnt} !== 14'd0) begin
            errors++; $display("FAIL reset_mid got %b exp 0", {bit_out, bit_valid, stuff_bit, stuff_err, sof, bus_idle, err_cnt});
        end
        reset = 1'b1;
    endtask

    task automatic test_err_saturate();
        int nerr;
        pulse_reset();
        nerr = 0;
        for (int e = 0; e < 300; e++) begin
            for (int i = 0; i < 11; i++) drive_bit(1'b1, 1'b0, 1'b0);
            for (int i = 0; i < 6; i++) drive_bit(1'b0, 1'b1, 1'b0);
            nerr += int'(stuff_err);
        end
        checks++;
        if (nerr !== 300) begin errors++; $display("FAIL sat_err_pulses got %0d exp 300", nerr); end
        checks++;
`ifdef CAN_STUFF_ERR_CNT_EN
        if (err_cnt !== 8'd255) begin errors++; $display("FAIL err_cnt_sat got %0d exp 255", err_cnt); end
`else
        if (err_cnt !== 8'd0) begin errors++; $display("FAIL err_cnt_tied got %0d exp 0", err_cnt); end
`endif
    endtask

    initial begin
        test_reset();
        test_idle_detect();
        test_stuff_removal();
        test_stuff_error();
        test_stuff_next_run();
        test_unstuffed();
        test_priority();
        test_reset_mid();
        test_err_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
